// File: rtl/params_pkg.sv
// ---------------------------------------------------------------------------
// params_pkg
// Shared display-pipeline constants used as parameter defaults by the
// sequencing and timing blocks.
//   BRIGHTNESS_LEVELS : number of binary-weighted bit planes per row
// ---------------------------------------------------------------------------
package params_pkg;
  localparam int BRIGHTNESS_LEVELS = 8;
endpackage

// File: rtl/bitplane_sequencer.sv
// ---------------------------------------------------------------------------
// bitplane_sequencer
// Walks a LED matrix through every (row, bit plane) pair.  For each pair it
// asks the column shifter to load the plane, waits until the previous OE
// window has closed, pulses row_latch to transfer the shifted data to the
// display, records which row/plane is now shown and then advances to the
// next plane (and the next row after the last plane).  The next shift may
// start while the current display window is still running once that window
// is past its overlap point.
//
// Ports
//   clk_in                 : clock, all state changes on the rising edge
//   reset                  : asynchronous, active-high reset
//   enable                 : run request (looked at only between latches)
//   shift_done             : one-cycle pulse, shifter finished loading
//   output_enable          : display OE window currently running
//   exceeded_overlap_time  : OE window is past its overlap point
//   shift_start            : one-cycle request to load load_mask/load_row
//   load_mask              : one-hot plane being loaded
//   load_row               : row being loaded
//   row_latch              : latch pulse, LATCH_CYCLES clocks wide
//   brightness_mask_active : one-hot plane currently displayed
//   row_address            : row currently displayed
//   frame_start            : one-cycle pulse when row 0 plane 0 is latched
// ---------------------------------------------------------------------------
module bitplane_sequencer #(
  parameter int BRIGHTNESS_LEVELS = params_pkg::BRIGHTNESS_LEVELS,
  parameter int ROW_COUNT         = 16,
  parameter int LATCH_CYCLES      = 2
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         shift_done,
  input  logic                         output_enable,
  input  logic                         exceeded_overlap_time,
  output logic                         shift_start,
  output logic [BRIGHTNESS_LEVELS-1:0] load_mask,
  output logic [$clog2(ROW_COUNT)-1:0] load_row,
  output logic                         row_latch,
  output logic [BRIGHTNESS_LEVELS-1:0] brightness_mask_active,
  output logic [$clog2(ROW_COUNT)-1:0] row_address,
  output logic                         frame_start
);

  localparam int ROW_W = $clog2(ROW_COUNT);
  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_SHIFT_REQ    = 3'd1;
  localparam logic [2:0] ST_SHIFT_WAIT   = 3'd2;
  localparam logic [2:0] ST_OE_WAIT      = 3'd3;
  localparam logic [2:0] ST_LATCH        = 3'd4;
  localparam logic [2:0] ST_ADVANCE      = 3'd5;
  localparam logic [2:0] ST_OVERLAP_WAIT = 3'd6;

  logic [2:0]                   state_q, state_d;
  logic [CNT_W-1:0]             latch_cnt_q, latch_cnt_d;
  logic                         shift_start_q, shift_start_d;
  logic                         row_latch_q, row_latch_d;
  logic                         frame_start_q, frame_start_d;
  logic [BRIGHTNESS_LEVELS-1:0] load_mask_q, load_mask_d;
  logic [BRIGHTNESS_LEVELS-1:0] active_mask_q, active_mask_d;
  logic [ROW_W-1:0]             load_row_q, load_row_d;
  logic [ROW_W-1:0]             row_addr_q, row_addr_d;
  logic                         enter_latch;

  // Next-state logic.  enable is only consulted in IDLE and OVERLAP_WAIT so a
  // latch that has been started always runs through ADVANCE before stopping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:         if (enable) state_d = ST_SHIFT_REQ;
      ST_SHIFT_REQ:    state_d = ST_SHIFT_WAIT;
      ST_SHIFT_WAIT:   if (shift_done) state_d = ST_OE_WAIT;
      ST_OE_WAIT:      if (!output_enable) state_d = ST_LATCH;
      ST_LATCH:        if (latch_cnt_q == LATCH_LAST) state_d = ST_ADVANCE;
      ST_ADVANCE:      state_d = ST_OVERLAP_WAIT;
      ST_OVERLAP_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!output_enable || exceeded_overlap_time) begin
          state_d = ST_SHIFT_REQ;
        end
      end
      default:         state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.  Pulse outputs are computed from the
  // state being entered so that, once registered, they line up with that
  // state.  The displayed row/plane is captured on the way into LATCH, and
  // the rotate naturally wraps the top plane back to bit 0.
  always_comb begin
    enter_latch   = (state_q == ST_OE_WAIT) && (state_d == ST_LATCH);
    shift_start_d = (state_d == ST_SHIFT_REQ);
    row_latch_d   = (state_d == ST_LATCH);
    frame_start_d = enter_latch && (load_row_q == '0) && load_mask_q[0];
    latch_cnt_d   = '0;
    if ((state_q == ST_LATCH) && (state_d == ST_LATCH)) begin
      latch_cnt_d = latch_cnt_q + CNT_W'(1);
    end
    active_mask_d = enter_latch ? load_mask_q : active_mask_q;
    row_addr_d    = enter_latch ? load_row_q : row_addr_q;
    load_mask_d   = load_mask_q;
    load_row_d    = load_row_q;
    if (state_q == ST_ADVANCE) begin
      load_mask_d = {load_mask_q[BRIGHTNESS_LEVELS-2:0], load_mask_q[BRIGHTNESS_LEVELS-1]};
      if (load_mask_q[BRIGHTNESS_LEVELS-1]) begin
        load_row_d = load_row_q + ROW_W'(1);
      end
    end
  end

  // State registers; reset drops everything back to row 0 plane 0 at once,
  // even in the middle of a latch pulse.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      latch_cnt_q   <= '0;
      shift_start_q <= 1'b0;
      row_latch_q   <= 1'b0;
      frame_start_q <= 1'b0;
      load_mask_q   <= BRIGHTNESS_LEVELS'(1);
      active_mask_q <= BRIGHTNESS_LEVELS'(1);
      load_row_q    <= '0;
      row_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      latch_cnt_q   <= latch_cnt_d;
      shift_start_q <= shift_start_d;
      row_latch_q   <= row_latch_d;
      frame_start_q <= frame_start_d;
      load_mask_q   <= load_mask_d;
      active_mask_q <= active_mask_d;
      load_row_q    <= load_row_d;
      row_addr_q    <= row_addr_d;
    end
  end

  assign shift_start            = shift_start_q;
  assign load_mask              = load_mask_q;
  assign load_row               = load_row_q;
  assign row_latch              = row_latch_q;
  assign brightness_mask_active = active_mask_q;
  assign row_address            = row_addr_q;
  assign frame_start            = frame_start_q;

endmodule

// File: tb/tb_bitplane_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bitplane_sequencer
// Scoreboard bench for bitplane_sequencer with 4 planes, 4 rows and a
// 2-cycle latch.  A shifter model answers each shift_start and pushes the
// row/plane it expects the following latch to show; an OE model opens a
// 100-cycle display window after latches when overlap mode is on; a monitor
// pops and compares on every row_latch rising edge.
// ---------------------------------------------------------------------------
module tb_bitplane_sequencer;

  localparam int BL = 4;
  localparam int RC = 4;
  localparam int LC = 2;

  typedef struct {
    logic [1:0] row;
    logic [3:0] mask;
    logic       frame;
    int         doneCyc;
  } expEntry_t;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       enable;
  logic       shift_done;
  logic       output_enable;
  logic       exceeded_overlap_time;
  logic       shift_start;
  logic [3:0] load_mask;
  logic [1:0] load_row;
  logic       row_latch;
  logic [3:0] brightness_mask_active;
  logic [1:0] row_address;
  logic       frame_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int latchCount = 0;
  int shiftCount = 0;
  int resetCount = 0;
  int shiftDelay = 3;
  int overlapMode = 0;
  int oeLowCyc = -100;
  int exceededCyc = -1;
  int expRow = 0;
  int expPlane = 0;
  expEntry_t sbQ[$];

  bitplane_sequencer #(
    .BRIGHTNESS_LEVELS(BL),
    .ROW_COUNT(RC),
    .LATCH_CYCLES(LC)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .enable(enable),
    .shift_done(shift_done),
    .output_enable(output_enable),
    .exceeded_overlap_time(exceeded_overlap_time),
    .shift_start(shift_start),
    .load_mask(load_mask),
    .load_row(load_row),
    .row_latch(row_latch),
    .brightness_mask_active(brightness_mask_active),
    .row_address(row_address),
    .frame_start(frame_start)
  );

  // 10 ns clock and a free-running cycle index for timing checks.
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives reset/enable just after a rising edge.
  task automatic applyStimulus(input logic rstVal, input logic enVal);
    @(posedge clk_in);
    #1;
    reset  = rstVal;
    enable = enVal;
  endtask

  task automatic waitLatches(input int target, input int budget);
    int n;
    n = 0;
    while (latchCount < target && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput($sformatf("reach_latch_%0d", target), (latchCount >= target), 1);
  endtask

  // Shifter model: shift_done comes shiftDelay cycles after shift_start; at
  // that moment the expected content of the following latch is queued.
  initial begin : shifter
    int myReset;
    expEntry_t e;
    myReset = 0;
    forever begin
      @(negedge clk_in);
      if (resetCount != myReset) begin
        myReset  = resetCount;
        expRow   = 0;
        expPlane = 0;
      end
      if (shift_start === 1'b1 && reset === 1'b0) begin
        repeat (shiftDelay) @(posedge clk_in);
        #1;
        shift_done = 1'b1;
        e.row     = 2'(expRow);
        e.mask    = 4'(1 << expPlane);
        e.frame   = (expRow == 0 && expPlane == 0);
        e.doneCyc = cyc;
        sbQ.push_back(e);
        if (expPlane == BL - 1) begin
          expPlane = 0;
          expRow   = (expRow + 1) % RC;
        end else begin
          expPlane++;
        end
        @(posedge clk_in);
        #1;
        shift_done = 1'b0;
      end
    end
  end

  // OE model: in overlap mode each latch is followed by a 100-cycle display
  // window, with the overlap point raised at window cycle 68.
  initial begin : oeModel
    logic prevLatch;
    prevLatch = 1'b0;
    forever begin
      @(negedge clk_in);
      if (overlapMode != 0 && prevLatch && row_latch === 1'b0) begin
        for (int i = 0; i < 100; i++) begin
          @(posedge clk_in);
          #1;
          output_enable         = 1'b1;
          exceeded_overlap_time = (i >= 68);
          if (i == 68) exceededCyc = cyc;
        end
        @(posedge clk_in);
        #1;
        output_enable         = 1'b0;
        exceeded_overlap_time = 1'b0;
        oeLowCyc              = cyc;
      end
      prevLatch = row_latch;
    end
  end

  // Monitor: compares each latch against the scoreboard and watches latch
  // width, OE overlap and the shift request following the overlap point.
  initial begin : monitor
    expEntry_t e;
    int monReset;
    int handledExc;
    int width;
    int expLatch;
    logic latchPrev;
    logic ssPrev;
    monReset   = 0;
    handledExc = -1;
    width      = 0;
    latchPrev  = 1'b0;
    ssPrev     = 1'b0;
    forever begin
      @(negedge clk_in);
      if (resetCount != monReset) begin
        monReset  = resetCount;
        latchPrev = 1'b0;
        width     = 0;
      end
      if (shift_start === 1'b1 && !ssPrev) begin
        shiftCount++;
        if (exceededCyc >= 0 && exceededCyc != handledExc) begin
          handledExc = exceededCyc;
          checkOutput("shift_after_overlap_cycle", cyc, exceededCyc + 1);
        end
      end
      ssPrev = (shift_start === 1'b1);
      if (row_latch === 1'b1) begin
        checkOutput("latch_while_oe", output_enable, 0);
        if (!latchPrev) begin
          latchCount++;
          width = 1;
          if (sbQ.size() == 0) begin
            checkOutput("unexpected_latch", 1, 0);
          end else begin
            e = sbQ.pop_front();
            expLatch = (e.doneCyc + 2 > oeLowCyc + 1) ? e.doneCyc + 2 : oeLowCyc + 1;
            checkOutput($sformatf("latch%0d_row", latchCount), row_address, e.row);
            checkOutput($sformatf("latch%0d_mask", latchCount), brightness_mask_active, e.mask);
            checkOutput($sformatf("latch%0d_frame", latchCount), frame_start, e.frame);
            checkOutput($sformatf("latch%0d_cycle", latchCount), cyc, expLatch);
            checkOutput("load_mask_onehot", $onehot(load_mask), 1);
          end
        end else begin
          width++;
        end
      end else if (latchPrev) begin
        checkOutput("latch_width", width, LC);
      end
      latchPrev = (row_latch === 1'b1);
    end
  end

  initial begin : mainSeq
    int savedShift;
    int n;
    reset                 = 1'b1;
    enable                = 1'b1;
    shift_done            = 1'b0;
    output_enable         = 1'b0;
    exceeded_overlap_time = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("rst_load_mask", load_mask, 4'b0001);
    checkOutput("rst_active_mask", brightness_mask_active, 4'b0001);
    checkOutput("rst_load_row", load_row, 0);
    checkOutput("rst_row_address", row_address, 0);
    checkOutput("rst_row_latch", row_latch, 0);
    checkOutput("rst_shift_start", shift_start, 0);
    checkOutput("rst_frame_start", frame_start, 0);

    // Start-up: shift request on the first clock after release.
    applyStimulus(1'b0, 1'b1);
    @(negedge clk_in);
    checkOutput("startup_shift_cycle0", shift_start, 0);
    @(negedge clk_in);
    checkOutput("startup_shift_cycle1", shift_start, 1);

    // A full frame plus the wrap back to row 0 plane 0.
    waitLatches(17, 400);

    // Two overlapped display windows.
    overlapMode = 1;
    waitLatches(19, 500);
    overlapMode = 0;

    // Stalled shifter: nothing may latch while shift_done is withheld.
    shiftDelay = 50;
    savedShift = shiftCount;
    n = 0;
    while (shiftCount == savedShift && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("stall_shift_seen", (shiftCount > savedShift), 1);
    repeat (40) @(negedge clk_in);
    checkOutput("stall_latch_count", latchCount, 19);
    checkOutput("stall_row_latch", row_latch, 0);
    checkOutput("stall_active_mask", brightness_mask_active, 4'b0100);
    checkOutput("stall_row_address", row_address, 0);
    waitLatches(20, 100);
    shiftDelay = 3;

    // Enable dropped during latch 21 (row 1 plane 0).
    waitLatches(21, 100);
    applyStimulus(1'b0, 1'b0);
    savedShift = shiftCount;
    repeat (30) @(negedge clk_in);
    checkOutput("drop_no_shift", shiftCount, savedShift);
    checkOutput("drop_latch_count", latchCount, 21);
    checkOutput("drop_load_mask", load_mask, 4'b0010);
    checkOutput("drop_load_row", load_row, 1);
    checkOutput("drop_active_mask", brightness_mask_active, 4'b0001);
    checkOutput("drop_row_address", row_address, 1);
    applyStimulus(1'b0, 1'b1);

    // Reset pulse in the middle of the row 2 plane 2 latch.
    waitLatches(27, 100);
    checkOutput("pre_reset_latch", row_latch, 1);
    checkOutput("pre_reset_row", row_address, 2);
    checkOutput("pre_reset_mask", brightness_mask_active, 4'b0100);
    #1;
    reset = 1'b1;
    resetCount++;
    #1;
    checkOutput("async_rst_latch", row_latch, 0);
    checkOutput("async_rst_active_mask", brightness_mask_active, 4'b0001);
    checkOutput("async_rst_row_address", row_address, 0);
    checkOutput("async_rst_load_mask", load_mask, 4'b0001);
    checkOutput("async_rst_load_row", load_row, 0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    waitLatches(29, 100);
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
